ram_sdp_sr_sw_be: RTL
=====================

Name: ram_sdp_sr_sw_be

Overview:
Parametrised simple-dual-port synchronous RAM: one write port and one read port on a single clock, with per-byte write enables and write-first same-address forwarding. Read latency is configurable (1 or 2), with a matching rd_valid strobe. After reset, a hardware init sequencer zeroes the whole array before accepting traffic. Successor to the single-port sync/async RAM family; intended as the generic on-chip buffer for FIFOs and lookup tables.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 8, address width in bits.
RAM_DEPTH, 1<<ADDR_WIDTH, number of words; must be <= 2**ADDR_WIDTH.
RD_LATENCY, 1, cycles from rd_en to rd_data/rd_valid; legal values are 1 and 2.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  write request.
wr_addr  in  ADDR_WIDTH  write address.
wr_be  in  DATA_WIDTH/8  byte enables; bit i covers data[8i+7:8i].
wr_data  in  DATA_WIDTH  write data.
rd_en  in  1  read request.
rd_addr  in  ADDR_WIDTH  read address.
rd_data  out  DATA_WIDTH  read data, qualified by rd_valid.
rd_valid  out  1  rd_data valid strobe.
init_busy  out  1  high while the array is being zeroed; requests are ignored.
parity_err  out  1  present only with RAM_PARITY_EN.

Behaviour:
- Clocking and reset: one clock (clk); synchronous, active-high reset (rst).
- Reset values while rst=1: rd_data=0, rd_valid=0, init_busy=1, parity_err=0, init counter=0, FSM state=INIT. Array contents are not reset directly.
- FSM states:
  - INIT: each cycle writes 0 to mem[cnt] (and zero parity), then cnt++.
  - INIT -> READY: on the cycle after cnt==RAM_DEPTH-1 is written.
  - READY: normal operation.
  - READY -> INIT: only via rst.
- init_busy=1 in INIT. Array zeroing takes exactly RAM_DEPTH cycles after rst deasserts.
- Reset mid-INIT restarts from address 0. Reset mid-read flushes the pipeline, so rd_valid=0 on the next edge.
- In INIT, wr_en and rd_en are ignored: no array write, no rd_valid.
- Write (READY, wr_en=1): for each i with wr_be[i]=1, mem[wr_addr] byte i takes wr_data byte i; other bytes are unchanged. wr_be=0 is a no-op.
- Read (READY, rd_en=1): the array is sampled at edge N.
  - RD_LATENCY=1: rd_data/rd_valid are updated at edge N.
  - RD_LATENCY=2: an extra output register, so the update is at edge N+1.
- rd_valid is high for exactly one cycle per accepted rd_en. Back-to-back reads give one result per cycle.
- rd_data holds its last value when rd_valid=0.
- Collision (wr_en & rd_en & wr_addr==rd_addr, same cycle): write-first. Enabled bytes return wr_data; other bytes return old contents.
- No forwarding for writes in later cycles; a read already sampled returns its sampled value.
- Out-of-range addresses (>= RAM_DEPTH): writes are dropped; reads return 0 with rd_valid=1.
- Illegal RD_LATENCY: elaboration-time error, raised via a generate-time check.

Optional Feature:
RAM_PARITY_EN
- Defined: each byte stores an extra even-parity bit, computed on write and forwarded on collision. On read, the stored parity is checked per byte. parity_err pulses high aligned with rd_valid if any enabled-read byte mismatches; data is passed through unchanged. Init writes parity 0, which is consistent for zero data.
- Undefined: no parity storage, no parity_err port, and the array is DATA_WIDTH wide.

Decomposition:
- Shared package ram_pkg:
  - FSM state enum (INIT, READY).
  - Function to compute BE_WIDTH = DATA_WIDTH/8.
  - Byte-merge function (old, new, be).
  - Parity function.
- One sub-module, ram_init_seq: counter plus FSM that generates init_busy, init address, and init write enable, muxed ahead of the array write port. The storage array and read pipeline stay in the top module.

Test Plan:
- Init: deassert rst, then check init_busy stays high exactly RAM_DEPTH (256) cycles. A read of address 0x10 issued during INIT gives no rd_valid. A read of address 0x10 after INIT returns 0x00000000.
- Byte enables: write 0xAABBCCDD to address 5 with be=1111, then write 0x11223344 with be=0101. A read of address 5 returns 0xAA22CC44.
- Collision: mem[7]=0x01020304. Same-cycle write 0xFFFFFFFF with be=0011 and read of address 7. Returns 0x0102FFFF, and a later read also returns 0x0102FFFF.
- Latency: RD_LATENCY=2, back-to-back reads of addresses 1, 2, 3 on edges N..N+2. rd_valid is high on N+1..N+3 with the matching data, and data holds afterward.
- Reset mid-INIT: assert rst at init cycle 100 for 1 cycle. init_busy then lasts a full 256 cycles from release, and a pending rd_valid is suppressed.
- Parity (RAM_PARITY_EN): force-flip a stored bit of address 9 via the bench hook, then read address 9. parity_err=1 with rd_valid; a clean read of address 10 gives parity_err=0.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the simple-dual-port byte-enable RAM
package ram_pkg;
  typedef enum logic {INIT, READY} state_t;
  localparam int MAX_W = 1024;
  localparam int MAX_BE = MAX_W / 8;
  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction
  function automatic logic [MAX_W-1:0] merge(input logic [MAX_W-1:0] old_d, input logic [MAX_W-1:0] new_d, input logic [MAX_BE-1:0] be);
    merge = old_d;
    for (int i = 0; i < MAX_BE; i++)
      if (be[i]) merge[8*i+:8] = new_d[8*i+:8];
  endfunction
  function automatic logic [MAX_BE-1:0] byte_par(input logic [MAX_W-1:0] d);
    for (int i = 0; i < MAX_BE; i++)
      byte_par[i] = ^d[8*i+:8];
  endfunction
endpackage

// File: rtl/ram_init_seq.sv
// ram_init_seq: post-reset sequencer that sweeps every address with a zero write
module ram_init_seq
  import ram_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic [AW-1:0] addr,
  output logic          we
);
  state_t state, state_nx;
  logic [AW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  end
  always_comb state_nx = (state == INIT && cnt == AW'(DEPTH - 1)) ? READY : state;
  always_comb begin
    busy = state == INIT;
    we = state == INIT;
    addr = cnt;
  end
endmodule

// File: rtl/ram_sdp_sr_sw_be.sv
// ram_sdp_sr_sw_be: simple-dual-port RAM, byte enables, write-first collisions, 1/2-cycle read
// Optional per-byte even parity with parity_err output when RAM_PARITY_EN is defined.
module ram_sdp_sr_sw_be
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH = 1 << ADDR_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [be_width(DATA_WIDTH)-1:0]  wr_be,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             init_busy
`ifdef RAM_PARITY_EN
  ,output logic                            parity_err
`endif
);
  localparam int BW = be_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(RAM_DEPTH);
`ifdef RAM_PARITY_EN
  localparam int PW = DATA_WIDTH + 1;
`else
  localparam int PW = DATA_WIDTH;
`endif
  logic init_we, wr_fire, rd_fire, rd_in, hit, o_valid;
  logic [ADDR_WIDTH-1:0] init_addr;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] samp_data;
  logic [PW-1:0] samp_w, o_w;
  ram_init_seq #(.DEPTH(RAM_DEPTH), .AW(ADDR_WIDTH)) u_init (
    .clk(clk), .rst(rst), .busy(init_busy), .addr(init_addr), .we(init_we)
  );
  assign wr_fire = !init_busy && wr_en && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_fire = !init_busy && rd_en;
  assign rd_in = {1'b0, rd_addr} < DEPTH_W;
  assign hit = wr_fire && wr_addr == rd_addr;
  assign samp_data = !rd_in ? '0 :
                     hit ? DATA_WIDTH'(merge(MAX_W'(mem[rd_addr]), MAX_W'(wr_data), MAX_BE'(wr_be))) :
                     mem[rd_addr];
  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr] <= '0;
    else if (wr_fire)
      for (int i = 0; i < BW; i++)
        if (wr_be[i]) mem[wr_addr][8*i+:8] <= wr_data[8*i+:8];
  end
`ifdef RAM_PARITY_EN
  logic [BW-1:0] par [RAM_DEPTH];
  logic [BW-1:0] wr_par, samp_par;
  assign wr_par = BW'(byte_par(MAX_W'(wr_data)));
  assign samp_par = !rd_in ? '0 : hit ? (par[rd_addr] & ~wr_be) | (wr_par & wr_be) : par[rd_addr];
  assign samp_w = {|(BW'(byte_par(MAX_W'(samp_data))) ^ samp_par), samp_data};
  always_ff @(posedge clk) begin
    if (init_we) par[init_addr] <= '0;
    else if (wr_fire) par[wr_addr] <= (par[wr_addr] & ~wr_be) | (wr_par & wr_be);
  end
  always_ff @(posedge clk) parity_err <= !rst && o_valid && o_w[PW-1];
`else
  assign samp_w = samp_data;
`endif
  if (RD_LATENCY == 2) begin : g_lat2
    logic [PW-1:0] s_w;
    logic s_valid;
    always_ff @(posedge clk) begin
      s_valid <= !rst && rd_fire;
      if (rd_fire) s_w <= samp_w;
    end
    assign o_w = s_w;
    assign o_valid = s_valid;
  end else if (RD_LATENCY == 1) begin : g_lat1
    assign o_w = samp_w;
    assign o_valid = rd_fire;
  end else begin : g_bad
    $error("RD_LATENCY must be 1 or 2");
    assign o_w = '0;
    assign o_valid = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= o_valid;
      if (o_valid) rd_data <= o_w[DATA_WIDTH-1:0];
    end
  end
endmodule
